fifo_wptr_full: RTL and testbench

- Write-side pointer and full-flag controller for the async FIFO.
- Keeps the binary write pointer, which supplies the RAM write address.
- Converts the next pointer to Gray code and registers it for export to the read domain.
- Synchronises the read domain's Gray read pointer and derives full, almost-full, fill level and a sticky overflow flag.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_wptr_full_if.sv | 26 ++
 rtl/binary_to_gray.sv | 9 +
 rtl/fifo_wptr_full.sv | 78 +++++++
 tb/tb_fifo_wptr_full.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO pointer logic.
// Gray decode is width-agnostic: callers zero-extend into GRAY_MAX_W and truncate back.
package fifo_pkg;

  localparam int ADDR_SIZE  = 4;
  localparam int GRAY_MAX_W = 16;

  typedef logic [ADDR_SIZE:0]   ptr_t;
  typedef logic [ADDR_SIZE-1:0] addr_t;

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the async FIFO: request/clear in, pointers and status out.
interface fifo_wptr_full_if
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = fifo_pkg::ADDR_SIZE
);
  logic                 winc;
  logic [ADDR_SIZE:0]   rptr_gray;
  logic                 ovf_clr;
  logic [ADDR_SIZE-1:0] waddr;
  logic [ADDR_SIZE:0]   wptr_gray;
  logic                 wfull;
  logic                 walmost_full;
  logic [ADDR_SIZE:0]   wlevel;
  logic                 wovf;

  modport master (
    output winc, rptr_gray, ovf_clr,
    input  waddr, wptr_gray, wfull, walmost_full, wlevel, wovf
  );

  modport slave (
    input  winc, rptr_gray, ovf_clr,
    output waddr, wptr_gray, wfull, walmost_full, wlevel, wovf
  );
endinterface

// File: rtl/binary_to_gray.sv
// Combinational binary-to-Gray converter.
module binary_to_gray #(
  parameter int SIZE = 5
) (
  input  logic [SIZE-1:0] bin,
  output logic [SIZE-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full/level/overflow tracking for the async FIFO.
// The read pointer arrives in Gray code and is synchronised with two plain flops.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = fifo_pkg::ADDR_SIZE,
  parameter int AF_MARGIN = 2
) (
  input logic           clk,
  input logic           reset_n,
  fifo_wptr_full_if.slave bus
);
  localparam int PW    = ADDR_SIZE + 1;
  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [ADDR_SIZE:0] wbin;
  logic [ADDR_SIZE:0] wbin_next;
  logic [ADDR_SIZE:0] wgray_next;
  logic [ADDR_SIZE:0] rq1;
  logic [ADDR_SIZE:0] wq2_rptr;
  logic [ADDR_SIZE:0] rbin_s;
  logic [ADDR_SIZE:0] level_next;
  logic [ADDR_SIZE:0] full_cmp;
  logic               wen;
  logic               wptr_full;
  logic               walmost_full_r;
  logic [ADDR_SIZE:0] wlevel_r;
  logic               wovf_r;
  logic [ADDR_SIZE:0] wptr_gray_r;

  assign wen        = bus.winc & ~wptr_full;
  assign wbin_next  = wbin + {{ADDR_SIZE{1'b0}}, wen};
  assign rbin_s     = PW'(gray2bin(GRAY_MAX_W'(wq2_rptr)));
  assign level_next = wbin_next - rbin_s;
  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  assign full_cmp   = {~wq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wq2_rptr[ADDR_SIZE-2:0]};

  binary_to_gray #(.SIZE(PW)) u_b2g (
    .bin  (wbin_next),
    .gray (wgray_next)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wbin           <= '0;
      wptr_gray_r    <= '0;
      rq1            <= '0;
      wq2_rptr       <= '0;
      wptr_full      <= 1'b0;
      walmost_full_r <= 1'b0;
      wlevel_r       <= '0;
      wovf_r         <= 1'b0;
    end else begin
      rq1            <= bus.rptr_gray;
      wq2_rptr       <= rq1;
      wbin           <= wbin_next;
      wptr_gray_r    <= wgray_next;
      wptr_full      <= (wgray_next == full_cmp);
      wlevel_r       <= level_next;
      walmost_full_r <= (level_next >= AF_THRESH);
      // Set has priority so an overflow in the clearing cycle is not lost.
      if (bus.winc && wptr_full) begin
        wovf_r <= 1'b1;
      end else if (bus.ovf_clr) begin
        wovf_r <= 1'b0;
      end
    end
  end

  assign bus.waddr        = wbin[ADDR_SIZE-1:0];
  assign bus.wptr_gray    = wptr_gray_r;
  assign bus.wfull        = wptr_full;
  assign bus.walmost_full = walmost_full_r;
  assign bus.wlevel       = wlevel_r;
  assign bus.wovf         = wovf_r;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full with ADDR_SIZE=4, AF_MARGIN=2.
module tb_fifo_wptr_full;
  import fifo_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  fifo_wptr_full_if #(.ADDR_SIZE(4)) bus ();

  fifo_wptr_full #(.ADDR_SIZE(4), .AF_MARGIN(2)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic ptr_t to_gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_waddr"}, 32'(bus.waddr), 0);
    check({tag, "_wptr_gray"}, 32'(bus.wptr_gray), 0);
    check({tag, "_wfull"}, 32'(bus.wfull), 0);
    check({tag, "_walmost"}, 32'(bus.walmost_full), 0);
    check({tag, "_wlevel"}, 32'(bus.wlevel), 0);
    check({tag, "_wovf"}, 32'(bus.wovf), 0);
  endtask

  ptr_t exp_wbin;
  ptr_t prev_gray;
  ptr_t hold_rptr;

  initial begin
    checks        = 0;
    errors        = 0;
    reset_n       = 1'b0;
    bus.winc      = 1'b1;
    bus.rptr_gray = '0;
    bus.ovf_clr   = 1'b0;
    @(negedge clk);

    // Reset with writes requested
    tick();
    tick();
    check_all_zero("rst");
    reset_n  = 1'b1;
    bus.winc = 1'b0;
    tick();
    check_all_zero("rst_rel");

    // Fill 16 entries
    bus.winc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fill_waddr", 32'(bus.waddr), 32'(i));
      tick();
      check("fill_wlevel", 32'(bus.wlevel), 32'(i + 1));
      check("fill_walmost", 32'(bus.walmost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
      check("fill_wfull", 32'(bus.wfull), (i + 1 == 16) ? 32'd1 : 32'd0);
    end
    check("fill_wptr_gray", 32'(bus.wptr_gray), 32'b11000);

    // Writes while full are dropped and flagged
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ovf_waddr", 32'(bus.waddr), 0);
      check("ovf_wptr_gray", 32'(bus.wptr_gray), 32'b11000);
      check("ovf_wovf", 32'(bus.wovf), 1);
      check("ovf_wlevel", 32'(bus.wlevel), 16);
    end
    bus.winc    = 1'b0;
    bus.ovf_clr = 1'b1;
    tick();
    check("ovf_clr", 32'(bus.wovf), 0);
    bus.winc = 1'b1;
    tick();
    check("ovf_set_wins", 32'(bus.wovf), 1);
    check("ovf_set_wins_waddr", 32'(bus.waddr), 0);
    bus.winc    = 1'b0;
    bus.ovf_clr = 1'b0;

    // One read becomes visible three edges later
    bus.rptr_gray = 5'b00001;
    tick();
    check("drain_e1_wfull", 32'(bus.wfull), 1);
    tick();
    check("drain_e2_wfull", 32'(bus.wfull), 1);
    tick();
    check("drain_e3_wfull", 32'(bus.wfull), 0);
    check("drain_e3_wlevel", 32'(bus.wlevel), 15);
    check("drain_e3_walmost", 32'(bus.walmost_full), 1);

    // Bring read side to 14 before streaming so the lag stays small
    bus.rptr_gray = to_gray(5'd14);
    for (int i = 0; i < 3; i++) tick();
    check("pre_wrap_wlevel", 32'(bus.wlevel), 2);
    check("pre_wrap_walmost", 32'(bus.walmost_full), 0);

    // Stream 40 writes across the pointer wrap, reader two behind
    exp_wbin  = 5'd16;
    prev_gray = bus.wptr_gray;
    bus.winc  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.rptr_gray = to_gray(exp_wbin - 5'd2);
      tick();
      exp_wbin = exp_wbin + 5'd1;
      check("wrap_waddr", 32'(bus.waddr), 32'(exp_wbin[3:0]));
      check("wrap_wptr_gray", 32'(bus.wptr_gray), 32'(to_gray(exp_wbin)));
      check("wrap_gray_1bit", 32'($countones(bus.wptr_gray ^ prev_gray)), 1);
      check("wrap_wfull", 32'(bus.wfull), 0);
      check("wrap_wlevel", 32'(bus.wlevel), (i == 0) ? 32'd3 : (i == 1) ? 32'd4 : 32'd5);
      prev_gray = bus.wptr_gray;
    end
    check("wrap_end_wbin", 32'(exp_wbin), 24);

    // Freeze reader, settle, then write up to a level of 9
    hold_rptr = bus.rptr_gray;
    bus.winc  = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("settle_wlevel", 32'(bus.wlevel), 3);
    bus.winc = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("mid_wlevel", 32'(bus.wlevel), 9);
    check("mid_waddr", 32'(bus.waddr), 32'(4'd14));
    check("mid_rptr_held", 32'(bus.rptr_gray), 32'(hold_rptr));

    // Reset mid-burst with a nonzero read pointer on the input
    reset_n = 1'b0;
    tick();
    check_all_zero("rst_mid");
    check("rst_mid_rq1", 32'(u_dut.rq1), 0);
    check("rst_mid_wq2", 32'(u_dut.wq2_rptr), 0);

    // Normal operation resumes from zero
    reset_n       = 1'b1;
    bus.rptr_gray = '0;
    bus.winc      = 1'b1;
    tick();
    check("post_rst_waddr", 32'(bus.waddr), 1);
    check("post_rst_wlevel", 32'(bus.wlevel), 1);
    check("post_rst_wptr_gray", 32'(bus.wptr_gray), 1);
    bus.winc = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
